// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone arbiter with round-robin grant,
// per-cycle bus ownership and a slave-response watchdog.
// Master 0 is the CPU and master 1 is the external debug/loader port.
// The downstream wb_mux sees a single upstream master on the s_* side.

module wb_arbiter #(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  // Master 0 (CPU)
  input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
  input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
  input  logic                     m0_we_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_cyc_i,
  output logic                     m0_ack_o,
  output logic                     m0_err_o,
  output logic [WB_DATA_WIDTH-1:0] m0_data_o,

  // Master 1 (wb_ext)
  input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
  input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
  input  logic                     m1_we_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_cyc_i,
  output logic                     m1_ack_o,
  output logic                     m1_err_o,
  output logic [WB_DATA_WIDTH-1:0] m1_data_o,

  // Slave side
  output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
  output logic [WB_DATA_WIDTH-1:0] s_data_o,
  output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
  output logic                     s_we_o,
  output logic                     s_stb_o,
  output logic                     s_cyc_o,
  input  logic                     s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] s_data_i,

  // Status
  output logic [1:0]               owner_o,
  output logic                     timeout_o,
  output logic [7:0]               timeout_cnt_o
);

  // Watchdog counter width; kept at least one bit wide so that a disabled
  // watchdog (TIMEOUT_CYCLES == 0) still elaborates cleanly.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  // Counter value at which a still-stalled transfer is aborted.
  localparam logic [CNT_W-1:0] FIRE_AT =
    WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_ABORT  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  // Most recently granted master: 0 = m0, 1 = m1. Starts at 1 so m0 wins
  // the first contention after reset.
  logic               r_last;
  logic [1:0]         r_owner;
  logic [CNT_W-1:0]   r_wdCnt;
  logic [7:0]         r_timeoutCnt;

  logic               w_ownCyc;
  logic               w_ownStb;
  logic               w_stall;
  logic               w_fire;
  logic               w_otherReq;

  // Select the current owner's cyc/stb so the watchdog looks at one master.
  always_comb begin
    w_ownCyc = 1'b0;
    w_ownStb = 1'b0;
    case (r_state)
      ST_GRANT0: begin
        w_ownCyc = m0_cyc_i;
        w_ownStb = m0_stb_i;
      end
      ST_GRANT1: begin
        w_ownCyc = m1_cyc_i;
        w_ownStb = m1_stb_i;
      end
      default: begin
        w_ownCyc = 1'b0;
        w_ownStb = 1'b0;
      end
    endcase
  end

  // A stalled cycle is an active strobe from the owner with no slave ack.
  assign w_stall = w_ownCyc & w_ownStb & ~s_ack_i;
  assign w_fire  = WD_EN && w_stall && (r_wdCnt == FIRE_AT);

  // In ABORT the master that did not get aborted is the one we hand over to.
  assign w_otherReq = r_last ? m0_cyc_i : m1_cyc_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: round-robin in IDLE, hold while owner keeps cyc,
  // direct handover on release, one-cycle ABORT on watchdog expiry.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_nextState = r_last ? ST_GRANT0 : ST_GRANT1;
        end else if (m0_cyc_i) begin
          w_nextState = ST_GRANT0;
        end else if (m1_cyc_i) begin
          w_nextState = ST_GRANT1;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_GRANT0: begin
        if (!m0_cyc_i) begin
          w_nextState = m1_cyc_i ? ST_GRANT1 : ST_IDLE;
        end else if (w_fire) begin
          w_nextState = ST_ABORT;
        end else begin
          w_nextState = ST_GRANT0;
        end
      end
      ST_GRANT1: begin
        if (!m1_cyc_i) begin
          w_nextState = m0_cyc_i ? ST_GRANT0 : ST_IDLE;
        end else if (w_fire) begin
          w_nextState = ST_ABORT;
        end else begin
          w_nextState = ST_GRANT1;
        end
      end
      ST_ABORT: begin
        if (w_otherReq) begin
          w_nextState = r_last ? ST_GRANT0 : ST_GRANT1;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Output logic: steer the owner onto the slave side, route ack back to
  // the owner only, and flag the aborted master with err during ABORT.
  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (r_state)
      ST_GRANT0: begin
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_stb_o  = m0_stb_i & m0_cyc_i;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i;
      end
      ST_GRANT1: begin
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_stb_o  = m1_stb_i & m1_cyc_i;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i;
      end
      ST_ABORT: begin
        m0_err_o = ~r_last;
        m1_err_o = r_last;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

  // Read data is broadcast; only the owner's ack qualifies it.
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  // Remember which master was granted last, updated on entry to a grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
    end else if (w_nextState == ST_GRANT0) begin
      r_last <= 1'b0;
    end else if (w_nextState == ST_GRANT1) begin
      r_last <= 1'b1;
    end
  end

  // Registered one-hot owner, decoded from the next state so it tracks
  // r_state without any combinational path from the cyc inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner <= 2'b00;
    end else begin
      case (w_nextState)
        ST_GRANT0: r_owner <= 2'b01;
        ST_GRANT1: r_owner <= 2'b10;
        default:   r_owner <= 2'b00;
      endcase
    end
  end

  assign owner_o = r_owner;

  // Wait-state counter: counts stalled owner cycles, clears on ack, on a
  // dropped strobe and whenever the state changes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wdCnt <= '0;
    end else if ((w_nextState != r_state) || !w_stall) begin
      r_wdCnt <= '0;
    end else if (WD_EN) begin
      r_wdCnt <= r_wdCnt + 1'b1;
    end
  end

  // Saturating count of watchdog aborts, bumped as ABORT is entered so it
  // is already visible alongside the timeout pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timeoutCnt <= 8'd0;
    end else if (w_fire && (r_timeoutCnt != 8'hFF)) begin
      r_timeoutCnt <= r_timeoutCnt + 8'd1;
    end
  end

  assign timeout_o     = (r_state == ST_ABORT);
  assign timeout_cnt_o = r_timeoutCnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios for the two-master Wishbone arbiter,
// built with a 4-cycle watchdog so aborts are short to reach.

module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0Addr, m0DataW, m1Addr, m1DataW, sDataIn;
  logic [3:0]  m0Sel, m1Sel;
  logic        m0We, m0Stb, m0Cyc, m1We, m1Stb, m1Cyc, sAck;
  logic        m0Ack, m0Err, m1Ack, m1Err;
  logic [31:0] m0DataR, m1DataR, sAddr, sData;
  logic [3:0]  sSel;
  logic        sWe, sStb, sCyc;
  logic [1:0]  owner;
  logic        timeoutPulse;
  logic [7:0]  timeoutCnt;

  int checks = 0;
  int failures = 0;

  wb_arbiter #(
    .WB_DATA_WIDTH (32),
    .WB_ADDR_WIDTH (32),
    .WB_SEL_WIDTH  (4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .m0_addr_i    (m0Addr),
    .m0_data_i    (m0DataW),
    .m0_sel_i     (m0Sel),
    .m0_we_i      (m0We),
    .m0_stb_i     (m0Stb),
    .m0_cyc_i     (m0Cyc),
    .m0_ack_o     (m0Ack),
    .m0_err_o     (m0Err),
    .m0_data_o    (m0DataR),
    .m1_addr_i    (m1Addr),
    .m1_data_i    (m1DataW),
    .m1_sel_i     (m1Sel),
    .m1_we_i      (m1We),
    .m1_stb_i     (m1Stb),
    .m1_cyc_i     (m1Cyc),
    .m1_ack_o     (m1Ack),
    .m1_err_o     (m1Err),
    .m1_data_o    (m1DataR),
    .s_addr_o     (sAddr),
    .s_data_o     (sData),
    .s_sel_o      (sSel),
    .s_we_o       (sWe),
    .s_stb_o      (sStb),
    .s_cyc_o      (sCyc),
    .s_ack_i      (sAck),
    .s_data_i     (sDataIn),
    .owner_o      (owner),
    .timeout_o    (timeoutPulse),
    .timeout_cnt_o(timeoutCnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleMasters();
    m0Cyc = 1'b0; m0Stb = 1'b0; m0We = 1'b0;
    m1Cyc = 1'b0; m1Stb = 1'b0; m1We = 1'b0;
    sAck  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleMasters();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (owner !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_owner: got %b expected 00", owner);
    end
    checks++;
    if ({sCyc, sStb, sWe} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_slave: got %b expected 000", {sCyc, sStb, sWe});
    end
    checks++;
    if ({m0Ack, m1Ack, m0Err, m1Err, timeoutPulse} !== 5'b0) begin
      failures++; $display("[TB] FAIL reset_term: got %b expected 00000",
                           {m0Ack, m1Ack, m0Err, m1Err, timeoutPulse});
    end
    checks++;
    if (timeoutCnt !== 8'd0) begin
      failures++; $display("[TB] FAIL reset_tcnt: got %0d expected 0", timeoutCnt);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    tick();
    m0Cyc = 1'b1; m0Stb = 1'b1; m0Addr = 32'h0000_1000; m0We = 1'b0; m0Sel = 4'hF;
    @(negedge clk);
    checks++;
    if ({owner, sCyc} !== 3'b000) begin
      failures++; $display("[TB] FAIL single_latency: got %b expected 000", {owner, sCyc});
    end
    tick();
    @(negedge clk);
    checks++;
    if (owner !== 2'b01 || sCyc !== 1'b1 || sAddr !== 32'h0000_1000) begin
      failures++; $display("[TB] FAIL single_grant: got owner=%b cyc=%b addr=%h expected 01 1 00001000",
                           owner, sCyc, sAddr);
    end
    checks++;
    if ({m0Ack, m1Ack} !== 2'b00) begin
      failures++; $display("[TB] FAIL single_wait1: got %b expected 00", {m0Ack, m1Ack});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({m0Ack, m1Ack} !== 2'b00) begin
      failures++; $display("[TB] FAIL single_wait2: got %b expected 00", {m0Ack, m1Ack});
    end
    tick();
    sAck = 1'b1; sDataIn = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if ({m0Ack, m1Ack} !== 2'b10) begin
      failures++; $display("[TB] FAIL single_ack: got %b expected 10", {m0Ack, m1Ack});
    end
    checks++;
    if (m0DataR !== 32'hCAFE_F00D) begin
      failures++; $display("[TB] FAIL single_rdata: got %h expected cafef00d", m0DataR);
    end
    tick();
    sAck = 1'b0; m0Cyc = 1'b0; m0Stb = 1'b0;
    @(negedge clk);
    checks++;
    if (m1Ack !== 1'b0) begin
      failures++; $display("[TB] FAIL single_m1ack: got %b expected 0", m1Ack);
    end
    tick();
    @(negedge clk);
    checks++;
    if (owner !== 2'b00) begin
      failures++; $display("[TB] FAIL single_release: got %b expected 00", owner);
    end
  endtask

  task automatic test_contention();
    tick();
    rst = 1'b1;
    idleMasters();
    tick();
    rst = 1'b0;
    m0Cyc = 1'b1; m0Stb = 1'b1; m0Addr = 32'h0000_3000;
    m1Cyc = 1'b1; m1Stb = 1'b1; m1Addr = 32'h0000_4000; m1We = 1'b1; m1DataW = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (owner !== 2'b00) begin
      failures++; $display("[TB] FAIL cont_idle: got %b expected 00", owner);
    end
    tick();
    sAck = 1'b1;
    @(negedge clk);
    checks++;
    if (owner !== 2'b01 || sAddr !== 32'h0000_3000 || {m0Ack, m1Ack} !== 2'b10) begin
      failures++; $display("[TB] FAIL cont_first: got owner=%b addr=%h acks=%b expected 01 00003000 10",
                           owner, sAddr, {m0Ack, m1Ack});
    end
    tick();
    sAck = 1'b0; m0Cyc = 1'b0; m0Stb = 1'b0;
    @(negedge clk);
    checks++;
    if (m1Ack !== 1'b0) begin
      failures++; $display("[TB] FAIL cont_m1wait: got %b expected 0", m1Ack);
    end
    tick();
    sAck = 1'b1;
    @(negedge clk);
    checks++;
    if (owner !== 2'b10 || sCyc !== 1'b1 || sAddr !== 32'h0000_4000) begin
      failures++; $display("[TB] FAIL cont_handover: got owner=%b cyc=%b addr=%h expected 10 1 00004000",
                           owner, sCyc, sAddr);
    end
    checks++;
    if (sWe !== 1'b1 || sData !== 32'h1234_5678 || {m0Ack, m1Ack} !== 2'b01) begin
      failures++; $display("[TB] FAIL cont_m1xfer: got we=%b data=%h acks=%b expected 1 12345678 01",
                           sWe, sData, {m0Ack, m1Ack});
    end
    tick();
    idleMasters();
    tick();
    @(negedge clk);
    checks++;
    if (owner !== 2'b00) begin
      failures++; $display("[TB] FAIL cont_idle_end: got %b expected 00", owner);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] expOwner;
    tick();
    m0Cyc = 1'b1; m0Stb = 1'b1; m1Cyc = 1'b1; m1Stb = 1'b1; sAck = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expOwner = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      m0Cyc = 1'b1; m0Stb = 1'b1; m1Cyc = 1'b1; m1Stb = 1'b1; sAck = 1'b1;
      @(negedge clk);
      checks++;
      if (owner !== expOwner || {m1Ack, m0Ack} !== expOwner) begin
        failures++; $display("[TB] FAIL rr_grant%0d: got owner=%b acks=%b expected %b",
                             i, owner, {m1Ack, m0Ack}, expOwner);
      end
      tick();
      sAck = 1'b0;
      if (expOwner == 2'b01) begin
        m0Cyc = 1'b0; m0Stb = 1'b0;
      end else begin
        m1Cyc = 1'b0; m1Stb = 1'b0;
      end
    end
    tick();
    idleMasters();
    tick();
    tick();
  endtask

  task automatic test_lock();
    tick();
    m1Cyc = 1'b1; m1Stb = 1'b1; m1We = 1'b1; m1Addr = 32'h0000_2000;
    for (int b = 0; b < 4; b++) begin
      tick();
      if (b == 0) begin
        m0Cyc = 1'b1; m0Stb = 1'b1; m0Addr = 32'h0000_5000; m0We = 1'b0;
      end
      m1Addr = 32'h0000_2000 + 32'(b * 4);
      sAck = 1'b1;
      @(negedge clk);
      checks++;
      if (owner !== 2'b10 || sAddr !== 32'h0000_2000 + 32'(b * 4) || {m1Ack, m0Ack} !== 2'b10) begin
        failures++; $display("[TB] FAIL lock_beat%0d: got owner=%b addr=%h acks=%b expected 10 %h 10",
                             b, owner, sAddr, {m1Ack, m0Ack}, 32'h0000_2000 + 32'(b * 4));
      end
    end
    tick();
    sAck = 1'b0; m1Cyc = 1'b0; m1Stb = 1'b0; m1We = 1'b0;
    @(negedge clk);
    checks++;
    if (owner !== 2'b10 || m0Ack !== 1'b0) begin
      failures++; $display("[TB] FAIL lock_release: got owner=%b m0ack=%b expected 10 0", owner, m0Ack);
    end
    tick();
    sAck = 1'b1;
    @(negedge clk);
    checks++;
    if (owner !== 2'b01 || sAddr !== 32'h0000_5000 || m0Ack !== 1'b1) begin
      failures++; $display("[TB] FAIL lock_m0after: got owner=%b addr=%h ack=%b expected 01 00005000 1",
                           owner, sAddr, m0Ack);
    end
    tick();
    idleMasters();
    tick();
  endtask

  task automatic test_timeout();
    int pulses;
    int errs;
    tick();
    m0Cyc = 1'b1; m0Stb = 1'b1; m0Addr = 32'h0000_6000; sAck = 1'b0;
    for (int w = 0; w < 4; w++) begin
      tick();
      if (w == 0) begin
        m1Cyc = 1'b1; m1Stb = 1'b1; m1Addr = 32'h0000_7000;
      end
      @(negedge clk);
      checks++;
      if (owner !== 2'b01 || {sCyc, m0Err, timeoutPulse} !== 3'b100) begin
        failures++; $display("[TB] FAIL to_wait%0d: got owner=%b cyc/err/to=%b expected 01 100",
                             w, owner, {sCyc, m0Err, timeoutPulse});
      end
    end
    tick();
    sAck = 1'b1;
    @(negedge clk);
    checks++;
    if (owner !== 2'b00 || {sCyc, sStb} !== 2'b00) begin
      failures++; $display("[TB] FAIL to_abort_bus: got owner=%b cyc/stb=%b expected 00 00",
                           owner, {sCyc, sStb});
    end
    checks++;
    if ({m0Err, m1Err, m0Ack, m1Ack, timeoutPulse} !== 5'b10001) begin
      failures++; $display("[TB] FAIL to_abort_term: got %b expected 10001",
                           {m0Err, m1Err, m0Ack, m1Ack, timeoutPulse});
    end
    tick();
    sAck = 1'b0; m0Cyc = 1'b0; m0Stb = 1'b0;
    @(negedge clk);
    checks++;
    if (owner !== 2'b10 || sAddr !== 32'h0000_7000 || {timeoutPulse, m0Err} !== 2'b00) begin
      failures++; $display("[TB] FAIL to_m1grant: got owner=%b addr=%h to/err=%b expected 10 00007000 00",
                           owner, sAddr, {timeoutPulse, m0Err});
    end
    checks++;
    if (timeoutCnt !== 8'd1) begin
      failures++; $display("[TB] FAIL to_count1: got %0d expected 1", timeoutCnt);
    end
    tick();
    sAck = 1'b1;
    @(negedge clk);
    checks++;
    if (m1Ack !== 1'b1) begin
      failures++; $display("[TB] FAIL to_m1ack: got %b expected 1", m1Ack);
    end
    tick();
    idleMasters();
    // m0 now stalls forever: one abort every 6 cycles, 256 aborts in 1536.
    tick();
    m0Cyc = 1'b1; m0Stb = 1'b1;
    pulses = 0;
    errs = 0;
    for (int i = 0; i < 1536; i++) begin
      @(negedge clk);
      if (timeoutPulse === 1'b1) pulses++;
      if (m0Err === 1'b1) errs++;
      tick();
    end
    idleMasters();
    @(negedge clk);
    checks++;
    if (pulses != 256 || errs != 256) begin
      failures++; $display("[TB] FAIL to_pulses: got pulses=%0d errs=%0d expected 256 256", pulses, errs);
    end
    checks++;
    if (timeoutCnt !== 8'd255) begin
      failures++; $display("[TB] FAIL to_saturate: got %0d expected 255", timeoutCnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    m1Cyc = 1'b1; m1Stb = 1'b1; m1Addr = 32'h0000_8000; sAck = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (owner !== 2'b10 || sCyc !== 1'b1) begin
      failures++; $display("[TB] FAIL rmid_grant: got owner=%b cyc=%b expected 10 1", owner, sCyc);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m0Ack, m0Err, m1Ack, m1Err} !== 4'b0000) begin
      failures++; $display("[TB] FAIL rmid_during: got %b expected 0000", {m0Ack, m0Err, m1Ack, m1Err});
    end
    tick();
    rst = 1'b0;
    idleMasters();
    @(negedge clk);
    checks++;
    if (owner !== 2'b00 || sCyc !== 1'b0) begin
      failures++; $display("[TB] FAIL rmid_drop: got owner=%b cyc=%b expected 00 0", owner, sCyc);
    end
    checks++;
    if ({m0Ack, m0Err, m1Ack, m1Err, timeoutPulse} !== 5'b0) begin
      failures++; $display("[TB] FAIL rmid_term: got %b expected 00000",
                           {m0Ack, m0Err, m1Ack, m1Err, timeoutPulse});
    end
    checks++;
    if (timeoutCnt !== 8'd0) begin
      failures++; $display("[TB] FAIL rmid_tcnt: got %0d expected 0", timeoutCnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (owner !== 2'b00) begin
      failures++; $display("[TB] FAIL rmid_idle: got %b expected 00", owner);
    end
  endtask

  // Scenario sequence.
  initial begin
    rst = 1'b1;
    m0Addr = '0; m0DataW = '0; m0Sel = 4'hF;
    m1Addr = '0; m1DataW = '0; m1Sel = 4'hF;
    sDataIn = '0;
    idleMasters();
    $display("[TB] starting wb_arbiter scenarios");
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
